// File: rtl/wave_param_scheduler.sv
// -----------------------------------------------------------------------------
// wave_param_scheduler
//
// Frame-synchronous parameter sequencer for the wave-former video datapath.
// Parameter sets arrive from the regmap, are staged in shadow registers on
// cfg_commit and go live together on the next accepted start-of-frame. A frame
// therefore never sees a mix of old and new parameters. Wave amplitude is
// slewed by at most RAMP_STEP per frame toward its target. The block also
// owns the per-frame phase accumulator and the frame counter.
//
// Ports
//   s_axis_video_aclk    : video clock, the only clock of the block
//   s_axis_video_areset  : asynchronous, active-high reset
//   cfg_*                : staged parameter values (same clock domain)
//   cfg_commit           : one-cycle request to stage the cfg_* values
//   sof_fire             : accepted start-of-frame beat
//   run                  : 1 = phase advances each frame, 0 = phase frozen
//   phase_clr            : synchronous clear of phase and frame_cnt
//   x_offset .. phase_inc: active (committed) parameters, registered
//   phase, frame_cnt     : per-frame phase and accepted-frame count
//   commit_ack           : one-cycle pulse when a staged set goes live
//   state                : 0 IDLE, 1 ARMED, 2 RAMP
// -----------------------------------------------------------------------------
module wave_param_scheduler #(
   parameter logic [15:0] RAMP_STEP       = 16'd256,
   parameter logic [15:0] RESET_AMPLITUDE = 16'h7FFF
) (
   input  logic        s_axis_video_aclk,
   input  logic        s_axis_video_areset,
   input  logic [15:0] cfg_x_offset,
   input  logic [15:0] cfg_y_offset,
   input  logic [15:0] cfg_omega,
   input  logic [15:0] cfg_wave_amplitude,
   input  logic [15:0] cfg_decay_amplitude,
   input  logic [15:0] cfg_phase_inc,
   input  logic        cfg_commit,
   input  logic        sof_fire,
   input  logic        run,
   input  logic        phase_clr,
   output logic [15:0] x_offset,
   output logic [15:0] y_offset,
   output logic [15:0] omega,
   output logic [15:0] wave_amplitude,
   output logic [15:0] decay_amplitude,
   output logic [15:0] phase_inc,
   output logic [15:0] phase,
   output logic [15:0] frame_cnt,
   output logic        commit_ack,
   output logic [1:0]  state
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_RAMP  = 2'd2
   } state_t;

   state_t      state_q, state_d;

   logic [15:0] sh_x_offset, sh_y_offset, sh_omega;
   logic [15:0] sh_wave_amplitude, sh_decay_amplitude, sh_phase_inc;
   logic [15:0] amp_target;

   logic        commit_now;
   logic [15:0] amp_target_d;
   logic [15:0] wave_amp_d;

   assign state = state_q;

   // The commit uses the shadow contents from before this edge, so a
   // cfg_commit arriving together with the SOF only replaces the shadow.
   assign commit_now   = sof_fire && (state_q == ST_ARMED);
   assign amp_target_d = commit_now ? sh_wave_amplitude : amp_target;

   // Amplitude slew toward the (possibly just updated) target. The step is
   // only taken while the remaining distance exceeds RAMP_STEP, so the sum or
   // difference can neither overshoot nor wrap.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path
      // through the block leaves it unassigned (which would infer a latch).
      wave_amp_d = wave_amplitude;
      if (sof_fire) begin
         if (amp_target_d >= wave_amplitude) begin
            if ((RAMP_STEP == 16'd0) || ((amp_target_d - wave_amplitude) <= RAMP_STEP))
               wave_amp_d = amp_target_d;
            else
               wave_amp_d = wave_amplitude + RAMP_STEP;
         end else begin
            if ((RAMP_STEP == 16'd0) || ((wave_amplitude - amp_target_d) <= RAMP_STEP))
               wave_amp_d = amp_target_d;
            else
               wave_amp_d = wave_amplitude - RAMP_STEP;
         end
      end
   end

   // Next state looks at the post-commit, post-slew amplitude values.
   // A cfg_commit always lands in ARMED, which outranks RAMP.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (cfg_commit) state_d = ST_ARMED;
         end
         ST_ARMED: begin
            if (cfg_commit)
               state_d = ST_ARMED;
            else if (sof_fire)
               state_d = (wave_amp_d != amp_target_d) ? ST_RAMP : ST_IDLE;
         end
         ST_RAMP: begin
            if (cfg_commit)
               state_d = ST_ARMED;
            else if (sof_fire && (wave_amp_d == amp_target_d))
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge s_axis_video_aclk or posedge s_axis_video_areset) begin
      if (s_axis_video_areset) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, e.g. phase adds the old phase_inc while a
   // commit updates phase_inc on the same edge.
   always_ff @(posedge s_axis_video_aclk or posedge s_axis_video_areset) begin
      if (s_axis_video_areset) begin
         sh_x_offset        <= '0;
         sh_y_offset        <= '0;
         sh_omega           <= '0;
         sh_wave_amplitude  <= '0;
         sh_decay_amplitude <= '0;
         sh_phase_inc       <= '0;
         amp_target         <= RESET_AMPLITUDE;
         x_offset           <= '0;
         y_offset           <= '0;
         omega              <= '0;
         wave_amplitude     <= RESET_AMPLITUDE;
         decay_amplitude    <= '0;
         phase_inc          <= '0;
         phase              <= '0;
         frame_cnt          <= '0;
         commit_ack         <= 1'b0;
      end else begin
         if (cfg_commit) begin
            sh_x_offset        <= cfg_x_offset;
            sh_y_offset        <= cfg_y_offset;
            sh_omega           <= cfg_omega;
            sh_wave_amplitude  <= cfg_wave_amplitude;
            sh_decay_amplitude <= cfg_decay_amplitude;
            sh_phase_inc       <= cfg_phase_inc;
         end

         if (commit_now) begin
            x_offset        <= sh_x_offset;
            y_offset        <= sh_y_offset;
            omega           <= sh_omega;
            decay_amplitude <= sh_decay_amplitude;
            phase_inc       <= sh_phase_inc;
         end
         commit_ack     <= commit_now;
         amp_target     <= amp_target_d;
         wave_amplitude <= wave_amp_d;

         if (phase_clr) begin
            phase     <= '0;
            frame_cnt <= '0;
         end else if (sof_fire) begin
            frame_cnt <= frame_cnt + 16'd1;
            if (run) phase <= phase + phase_inc;
         end
      end
   end

endmodule

// File: tb/tb_wave_param_scheduler.sv
// -----------------------------------------------------------------------------
// tb_wave_param_scheduler
//
// Self-checking bench for wave_param_scheduler. A frame-level reference model
// (pending-set flag, target/amplitude pair, plain integer slew) predicts every
// output after each clock edge; directed scenarios add fixed expected values.
// -----------------------------------------------------------------------------
module tb_wave_param_scheduler;

   localparam logic [15:0] RAMP_STEP       = 16'h0400;
   localparam logic [15:0] RESET_AMPLITUDE = 16'h7FFF;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] cfg_x_offset = '0, cfg_y_offset = '0, cfg_omega = '0;
   logic [15:0] cfg_wave_amplitude = '0, cfg_decay_amplitude = '0, cfg_phase_inc = '0;
   logic        cfg_commit = 1'b0, sof_fire = 1'b0, run = 1'b0, phase_clr = 1'b0;

   logic [15:0] x_offset, y_offset, omega, wave_amplitude, decay_amplitude, phase_inc;
   logic [15:0] phase, frame_cnt;
   logic        commit_ack;
   logic [1:0]  state;

   wave_param_scheduler #(
      .RAMP_STEP       (RAMP_STEP),
      .RESET_AMPLITUDE (RESET_AMPLITUDE)
   ) dut (
      .s_axis_video_aclk   (clk),
      .s_axis_video_areset (rst),
      .cfg_x_offset        (cfg_x_offset),
      .cfg_y_offset        (cfg_y_offset),
      .cfg_omega           (cfg_omega),
      .cfg_wave_amplitude  (cfg_wave_amplitude),
      .cfg_decay_amplitude (cfg_decay_amplitude),
      .cfg_phase_inc       (cfg_phase_inc),
      .cfg_commit          (cfg_commit),
      .sof_fire            (sof_fire),
      .run                 (run),
      .phase_clr           (phase_clr),
      .x_offset            (x_offset),
      .y_offset            (y_offset),
      .omega               (omega),
      .wave_amplitude      (wave_amplitude),
      .decay_amplitude     (decay_amplitude),
      .phase_inc           (phase_inc),
      .phase               (phase),
      .frame_cnt           (frame_cnt),
      .commit_ack          (commit_ack),
      .state               (state)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   // ---------------- reference model ----------------
   logic [15:0] m_x, m_y, m_om, m_wave, m_dec, m_pinc, m_phase, m_fc, m_tgt;
   logic [15:0] s_x, s_y, s_om, s_amp, s_dec, s_pinc;
   logic        m_ack;
   bit          m_pending;   // a staged set is waiting for the next frame

   wire [130:0] dut_obs = {x_offset, y_offset, omega, wave_amplitude, decay_amplitude,
                           phase_inc, phase, frame_cnt, commit_ack, state};

   function automatic logic [130:0] exp_obs();
      logic [1:0] st;
      // ARMED whenever a set is pending, otherwise RAMP while not on target.
      st = m_pending ? 2'd1 : ((m_wave != m_tgt) ? 2'd2 : 2'd0);
      return {m_x, m_y, m_om, m_wave, m_dec, m_pinc, m_phase, m_fc, m_ack, st};
   endfunction

   task automatic model_reset();
      {m_x, m_y, m_om, m_dec, m_pinc, m_phase, m_fc} = '0;
      {s_x, s_y, s_om, s_amp, s_dec, s_pinc} = '0;
      m_wave = RESET_AMPLITUDE;
      m_tgt  = RESET_AMPLITUDE;
      m_ack  = 1'b0;
      m_pending = 1'b0;
   endtask

   task automatic model_edge();
      logic [15:0] old_pinc;
      int d;
      old_pinc = m_pinc;
      m_ack = 1'b0;
      if (sof_fire) begin
         if (m_pending) begin
            m_x = s_x; m_y = s_y; m_om = s_om; m_dec = s_dec; m_pinc = s_pinc;
            m_tgt = s_amp;
            m_ack = 1'b1;
         end
         d = int'(m_tgt) - int'(m_wave);
         if (RAMP_STEP == 16'd0 || (d <= int'(RAMP_STEP) && d >= -int'(RAMP_STEP)))
            m_wave = m_tgt;
         else if (d > 0)
            m_wave = m_wave + RAMP_STEP;
         else
            m_wave = m_wave - RAMP_STEP;
         m_fc = m_fc + 16'd1;
         if (run) m_phase = m_phase + old_pinc;
      end
      if (phase_clr) begin
         m_phase = '0;
         m_fc    = '0;
      end
      if (cfg_commit) begin
         s_x = cfg_x_offset; s_y = cfg_y_offset; s_om = cfg_omega;
         s_amp = cfg_wave_amplitude; s_dec = cfg_decay_amplitude; s_pinc = cfg_phase_inc;
         m_pending = 1'b1;
      end else if (sof_fire) begin
         m_pending = 1'b0;
      end
   endtask

   // One clock: inputs applied at negedge, model advanced at the edge,
   // outputs settle for sampling at the following negedge.
   task automatic step(input bit c, input bit s, input bit r, input bit k);
      cfg_commit = c; sof_fire = s; run = r; phase_clr = k;
      @(posedge clk);
      model_edge();
      cyc++;
      @(negedge clk);
      cfg_commit = 1'b0; sof_fire = 1'b0; phase_clr = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      rst = 1'b1;
      model_reset();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (dut_obs !== exp_obs()) begin
         n_fail++; $display("FAIL reset_outputs: got %h expected %h", dut_obs, exp_obs());
      end
      n_checks++;
      if (wave_amplitude !== 16'h7FFF || state !== 2'd0 || phase !== 16'h0 || x_offset !== 16'h0) begin
         n_fail++; $display("FAIL reset_values: amp %h state %0d phase %h x %h, expected 7fff 0 0000 0000",
                            wave_amplitude, state, phase, x_offset);
      end
   endtask

   task automatic test_phase_commit();
      logic [15:0] exp_ph [3] = '{16'h0000, 16'h0100, 16'h0200};
      int acks = 0;
      cfg_wave_amplitude = 16'h7FFF;
      cfg_phase_inc = 16'h0100;
      step(1, 0, 1, 0);
      n_checks++;
      if (state !== 2'd1) begin
         n_fail++; $display("FAIL phase_armed: state %0d expected 1", state);
      end
      for (int i = 0; i < 3; i++) begin
         step(0, 1, 1, 0);
         acks += int'(commit_ack);
         n_checks++;
         if (phase !== exp_ph[i] || dut_obs !== exp_obs()) begin
            n_fail++; $display("FAIL phase_seq[%0d]: phase %h expected %h (obs %h model %h)",
                               i, phase, exp_ph[i], dut_obs, exp_obs());
         end
      end
      n_checks++;
      if (acks != 1) begin
         n_fail++; $display("FAIL phase_ack_count: got %0d expected 1", acks);
      end
   endtask

   task automatic test_ramp();
      logic [15:0] exp_amp [4] = '{16'h7BFF, 16'h77FF, 16'h73FF, 16'h7000};
      logic [1:0]  exp_st  [4] = '{2'd2, 2'd2, 2'd2, 2'd0};
      cfg_wave_amplitude = 16'h7000;
      step(1, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         step(0, 1, 0, 0);
         n_checks++;
         if (wave_amplitude !== exp_amp[i] || state !== exp_st[i] || dut_obs !== exp_obs()) begin
            n_fail++; $display("FAIL ramp[%0d]: amp %h state %0d expected %h %0d",
                               i, wave_amplitude, state, exp_amp[i], exp_st[i]);
         end
      end
   endtask

   task automatic test_simultaneous();
      logic [15:0] x_before;
      x_before = x_offset;
      cfg_x_offset = 16'h0040;
      step(1, 1, 0, 0);
      n_checks++;
      if (x_offset !== x_before || state !== 2'd1 || commit_ack !== 1'b0 || dut_obs !== exp_obs()) begin
         n_fail++; $display("FAIL simul_first: x %h state %0d ack %b expected %h 1 0",
                            x_offset, state, commit_ack, x_before);
      end
      step(0, 1, 0, 0);
      n_checks++;
      if (x_offset !== 16'h0040 || commit_ack !== 1'b1 || dut_obs !== exp_obs()) begin
         n_fail++; $display("FAIL simul_second: x %h ack %b expected 0040 1", x_offset, commit_ack);
      end
   endtask

   task automatic test_double_commit();
      int acks = 0;
      cfg_x_offset = 16'h0010;
      step(1, 0, 0, 0);
      cfg_x_offset = 16'h0020;
      step(1, 0, 0, 0);
      for (int i = 0; i < 3; i++) begin
         step(0, (i == 0), 0, 0);
         acks += int'(commit_ack);
      end
      n_checks++;
      if (x_offset !== 16'h0020 || acks != 1 || dut_obs !== exp_obs()) begin
         n_fail++; $display("FAIL double_commit: x %h acks %0d expected 0020 1", x_offset, acks);
      end
   endtask

   task automatic test_frame_wrap();
      while (m_fc != 16'hFFFF) step(0, 1, 1, 0);
      n_checks++;
      if (frame_cnt !== 16'hFFFF || dut_obs !== exp_obs()) begin
         n_fail++; $display("FAIL wrap_preset: frame_cnt %h expected ffff", frame_cnt);
      end
      step(0, 1, 1, 0);
      n_checks++;
      if (frame_cnt !== 16'h0000) begin
         n_fail++; $display("FAIL wrap_zero: frame_cnt %h expected 0000", frame_cnt);
      end
      step(0, 1, 1, 0);
      step(0, 1, 1, 1);
      n_checks++;
      if (phase !== 16'h0000 || frame_cnt !== 16'h0000 || dut_obs !== exp_obs()) begin
         n_fail++; $display("FAIL clr_with_sof: phase %h frame_cnt %h expected 0000 0000", phase, frame_cnt);
      end
   endtask

   task automatic test_reset_mid();
      cfg_wave_amplitude = 16'h0100;
      step(1, 0, 0, 0);
      #2 rst = 1'b1;
      #1;
      model_reset();
      n_checks++;
      if (dut_obs !== exp_obs()) begin
         n_fail++; $display("FAIL reset_async: got %h expected %h", dut_obs, exp_obs());
      end
      @(negedge clk);
      rst = 1'b0;
      step(0, 1, 1, 0);
      n_checks++;
      if (commit_ack !== 1'b0 || wave_amplitude !== RESET_AMPLITUDE || dut_obs !== exp_obs()) begin
         n_fail++; $display("FAIL reset_discard: ack %b amp %h expected 0 7fff", commit_ack, wave_amplitude);
      end
   endtask

   task automatic test_random();
      int errs = 0;
      for (int i = 0; i < 2000; i++) begin
         cfg_x_offset        = 16'($urandom);
         cfg_y_offset        = 16'($urandom);
         cfg_omega           = 16'($urandom);
         cfg_wave_amplitude  = 16'($urandom);
         cfg_decay_amplitude = 16'($urandom);
         cfg_phase_inc       = 16'($urandom);
         step(($urandom_range(0, 7) == 0), ($urandom_range(0, 2) == 0),
              1'($urandom), ($urandom_range(0, 31) == 0));
         n_checks++;
         if (dut_obs !== exp_obs()) begin
            n_fail++;
            if (errs < 10) $display("FAIL random cycle %0d: got %h expected %h", cyc, dut_obs, exp_obs());
            errs++;
         end
      end
   endtask

   initial begin
      test_reset();
      test_phase_commit();
      test_ramp();
      test_simultaneous();
      test_double_commit();
      test_frame_wrap();
      test_reset_mid();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
